// File: rtl/calculate_unit_hs.sv
// calculate_unit_hs: handshaked EX-stage integer unit. One-cycle RV32I ALU ops,
// iterative radix-2 RV32M multiply/divide, registered answer/error outputs.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake (number1, number2, mode)
//   out_valid/out_ready result handshake (answer, error)
//   busy                iterative multiply/divide in progress
module calculate_unit_hs #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] number1,
    input  logic [WIDTH-1:0] number2,
    input  logic [7:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] answer,
    output logic [3:0]       error,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_n1;
    logic [2:0]       r_op;
    logic             r_neg;
    logic             r_rneg;
    logic             r_dz;
    logic             r_ovf;
    logic [WIDTH-1:0] r_answer;
    logic [3:0]       r_error;

    logic             w_accept;
    logic             w_slow;
    logic             w_fast_legal;
    logic [SW-1:0]    w_shamt;
    logic             w_slt;
    logic             w_sltu;
    logic [WIDTH-1:0] w_fast_ans;
    logic [2:0]       w_op;
    logic             w_sgn1;
    logic             w_sgn2;
    logic             w_neg1;
    logic             w_neg2;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic             w_dz;
    logic             w_ovf;

    logic [WIDTH:0]     w_madd;
    logic [WIDTH-1:0]   w_mhi;
    logic [WIDTH-1:0]   w_mlo;
    logic [WIDTH:0]     w_dsh;
    logic [WIDTH:0]     w_ddiff;
    logic               w_dq;
    logic [WIDTH-1:0]   w_dhi;
    logic [WIDTH-1:0]   w_dlo;
    logic [WIDTH-1:0]   w_nhi;
    logic [WIDTH-1:0]   w_nlo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_sprod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_slow_ans;

    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_BUSY);
    assign answer    = r_answer;
    assign error     = r_error;
    assign w_accept  = in_valid & in_ready;

    // Decode
    assign w_slow       = (mode[7:3] == 5'b01000);
    assign w_fast_legal = (mode <= 8'h09);
    assign w_shamt      = number2[SW-1:0];
    assign w_slt        = $signed(number1) < $signed(number2);
    assign w_sltu       = number1 < number2;

    always_comb begin
        w_fast_ans = '0;
        case (mode)
            8'h00: w_fast_ans = number1 - number2;
            8'h01: w_fast_ans = number1 + number2;
            8'h02: w_fast_ans = number1 & number2;
            8'h03: w_fast_ans = number1 | number2;
            8'h04: w_fast_ans = number1 ^ number2;
            8'h05: w_fast_ans = number1 >> w_shamt;
            8'h06: w_fast_ans = number1 << w_shamt;
            8'h07: w_fast_ans = $signed(number1) >>> w_shamt;
            8'h08: w_fast_ans = {{(WIDTH-1){1'b0}}, w_slt};
            8'h09: w_fast_ans = {{(WIDTH-1){1'b0}}, w_sltu};
            default: w_fast_ans = '0;
        endcase
    end

    // Operand signedness: MUL/MULH/DIV/REM signed x signed, MULHSU signed x unsigned
    assign w_op   = mode[2:0];
    assign w_sgn1 = (w_op == 3'd0) | (w_op == 3'd1) | (w_op == 3'd2)
                  | (w_op == 3'd4) | (w_op == 3'd6);
    assign w_sgn2 = (w_op == 3'd0) | (w_op == 3'd1)
                  | (w_op == 3'd4) | (w_op == 3'd6);
    assign w_neg1 = w_sgn1 & number1[WIDTH-1];
    assign w_neg2 = w_sgn2 & number2[WIDTH-1];
    assign w_abs1 = w_neg1 ? -number1 : number1;
    assign w_abs2 = w_neg2 ? -number2 : number2;
    assign w_dz   = w_op[2] & (number2 == '0);
    assign w_ovf  = w_op[2] & ~w_op[0]
                  & (number1 == {1'b1, {(WIDTH-1){1'b0}}})
                  & (&number2);

    // Multiply step: {r_hi, r_lo} shifts right, r_b added into the top half
    assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_mhi  = w_madd[WIDTH:1];
    assign w_mlo  = {w_madd[0], r_lo[WIDTH-1:1]};

    // Restoring divide step: r_hi is the partial remainder, r_lo the dividend/quotient.
    // The borrow out of bit WIDTH tells whether the subtract is kept.
    assign w_dsh   = {r_hi, r_lo[WIDTH-1]};
    assign w_ddiff = w_dsh - {1'b0, r_b};
    assign w_dq    = ~w_ddiff[WIDTH];
    assign w_dhi   = w_dq ? w_ddiff[WIDTH-1:0] : w_dsh[WIDTH-1:0];
    assign w_dlo   = {r_lo[WIDTH-2:0], w_dq};

    assign w_nhi = r_op[2] ? w_dhi : w_mhi;
    assign w_nlo = r_op[2] ? w_dlo : w_mlo;

    // Sign fix-up works on the post-step values so the last step and the
    // result register share one edge, keeping latency at WIDTH+1.
    assign w_prod  = {w_nhi, w_nlo};
    assign w_sprod = r_neg ? -w_prod : w_prod;
    assign w_quo   = r_neg ? -w_nlo : w_nlo;
    assign w_rem   = r_rneg ? -w_nhi : w_nhi;

    always_comb begin
        w_slow_ans = '0;
        case (r_op)
            3'd0:    w_slow_ans = w_sprod[WIDTH-1:0];
            3'd1,
            3'd2,
            3'd3:    w_slow_ans = w_sprod[2*WIDTH-1:WIDTH];
            3'd4,
            3'd5:    w_slow_ans = r_dz ? '1 : w_quo;
            default: w_slow_ans = r_dz ? r_n1 : w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_n1     <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_answer <= '0;
            r_error  <= '0;
        end else if (w_accept) begin
            if (w_slow) begin
                r_hi    <= '0;
                r_lo    <= w_abs1;
                r_b     <= w_abs2;
                r_n1    <= number1;
                r_op    <= w_op;
                r_neg   <= w_neg1 ^ w_neg2;
                r_rneg  <= w_neg1;
                r_dz    <= w_dz;
                r_ovf   <= w_ovf;
                r_cnt   <= CW'(WIDTH);
                r_state <= S_BUSY;
            end else begin
                r_answer <= w_fast_ans;
                r_error  <= {3'b000, ~w_fast_legal};
                r_state  <= S_DONE;
            end
        end else begin
            case (r_state)
                S_BUSY: begin
                    r_hi  <= w_nhi;
                    r_lo  <= w_nlo;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_answer <= w_slow_ans;
                        r_error  <= {1'b0, r_ovf, r_dz, 1'b0};
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calculate_unit_hs.sv
// tb_calculate_unit_hs: scoreboard bench for calculate_unit_hs at WIDTH=32 and WIDTH=8.
// Expected results come from an arithmetic reference model on 64-bit integers.
module tb_calculate_unit_hs;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    logic        iv32, ir32, ov32, or32, busy32;
    logic [31:0] a32, b32, ans32;
    logic [7:0]  m32;
    logic [3:0]  err32;

    logic        iv8, ir8, ov8, or8, busy8;
    logic [7:0]  a8, b8, ans8;
    logic [7:0]  m8;
    logic [3:0]  err8;

    logic rand_en, or_rnd, or_fix;
    assign or32 = rand_en ? or_rnd : or_fix;

    logic [35:0] q32[$];
    logic [35:0] q8[$];
    logic [35:0] e32, e8;
    int          obs_cyc[$];
    logic [31:0] obs_ans[$];

    calculate_unit_hs #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(iv32), .in_ready(ir32),
        .number1(a32), .number2(b32), .mode(m32),
        .out_valid(ov32), .out_ready(or32),
        .answer(ans32), .error(err32), .busy(busy32)
    );

    calculate_unit_hs #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .number1(a8), .number2(b8), .mode(m8),
        .out_valid(ov8), .out_ready(or8),
        .answer(ans8), .error(err8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        or_rnd = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            or_rnd = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands' numeric values.
    function automatic logic [35:0] model(input int w, input logic [7:0] m,
                                          input logic [31:0] a, input logic [31:0] b);
        longint mask, ua, ub, sa, sb, r, mn;
        longint unsigned up;
        int sh;
        logic [3:0] e;
        mask = (longint'(1) << w) - 1;
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = (((ua >> (w - 1)) & 1) != 0) ? ua - (longint'(1) << w) : ua;
        sb = (((ub >> (w - 1)) & 1) != 0) ? ub - (longint'(1) << w) : ub;
        mn = -(longint'(1) << (w - 1));
        sh = int'(ub % w);
        e = 4'b0000;
        r = 0;
        case (m)
            8'h00: r = ua - ub;
            8'h01: r = ua + ub;
            8'h02: r = ua & ub;
            8'h03: r = ua | ub;
            8'h04: r = ua ^ ub;
            8'h05: r = ua >> sh;
            8'h06: r = ua << sh;
            8'h07: r = sa >>> sh;
            8'h08: r = (sa < sb) ? 1 : 0;
            8'h09: r = (ua < ub) ? 1 : 0;
            8'h40: r = sa * sb;
            8'h41: r = (sa * sb) >>> w;
            8'h42: r = (sa * ub) >>> w;
            8'h43: begin
                up = longint'(ua * ub);
                r  = longint'(up >> w);
            end
            8'h44: begin
                if (ub == 0) begin r = -1; e = 4'b0010; end
                else if (sa == mn && sb == -1) begin r = sa; e = 4'b0100; end
                else r = sa / sb;
            end
            8'h45: begin
                if (ub == 0) begin r = -1; e = 4'b0010; end
                else r = ua / ub;
            end
            8'h46: begin
                if (ub == 0) begin r = ua; e = 4'b0010; end
                else if (sa == mn && sb == -1) begin r = 0; e = 4'b0100; end
                else r = sa % sb;
            end
            8'h47: begin
                if (ub == 0) begin r = ua; e = 4'b0010; end
                else r = ua % ub;
            end
            default: begin r = 0; e = 4'b0001; end
        endcase
        r = r & mask;
        return {e, r[31:0]};
    endfunction

    function automatic logic g_ov(input bit s);
        return s ? ov8 : ov32;
    endfunction
    function automatic logic g_ir(input bit s);
        return s ? ir8 : ir32;
    endfunction
    function automatic logic g_busy(input bit s);
        return s ? busy8 : busy32;
    endfunction
    function automatic logic [31:0] g_ans(input bit s);
        return s ? {24'b0, ans8} : ans32;
    endfunction
    function automatic logic [31:0] g_err(input bit s);
        return s ? {28'b0, err8} : {28'b0, err32};
    endfunction

    // Scoreboard monitors
    always @(negedge clk) begin
        if (!rst && ov32 && or32) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb32_unexpected: got %h expected none", ans32);
            end else begin
                e32 = q32.pop_front();
                chk("sb32_ans", ans32, e32[31:0]);
                chk("sb32_err", {28'b0, err32}, {28'b0, e32[35:32]});
            end
            obs_cyc.push_back(cyc);
            obs_ans.push_back(ans32);
        end
    end

    always @(negedge clk) begin
        if (!rst && ov8 && or8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb8_unexpected: got %h expected none", ans8);
            end else begin
                e8 = q8.pop_front();
                chk("sb8_ans", {24'b0, ans8}, {4'b0, e8[31:0]} & 32'hFF);
                chk("sb8_err", {28'b0, err8}, {28'b0, e8[35:32]});
            end
        end
    end

    // Holds in_valid until accepted or maxw cycles pass; pushes the expected
    // result on the accepting edge.
    task automatic issue(input bit s, input logic [7:0] m, input logic [31:0] a,
                         input logic [31:0] b, input int maxw, output bit acc);
        acc = 1'b0;
        if (s) begin iv8 = 1'b1; m8 = m; a8 = a[7:0]; b8 = b[7:0]; end
        else begin iv32 = 1'b1; m32 = m; a32 = a; b32 = b; end
        for (int i = 0; i < maxw && !acc; i++) begin
            @(negedge clk);
            if (g_ir(s)) begin
                acc = 1'b1;
                if (s) q8.push_back(model(8, m, a, b));
                else q32.push_back(model(32, m, a, b));
            end
            @(posedge clk);
            #1;
        end
        if (s) iv8 = 1'b0;
        else iv32 = 1'b0;
    endtask

    task automatic fast_chk(input bit s, input logic [7:0] m, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] ea,
                            input logic [3:0] ee, input string name);
        bit acc;
        issue(s, m, a, b, 1, acc);
        chk({name, "_acc"}, {31'b0, acc}, 32'd1);
        @(negedge clk);
        chk({name, "_ov"}, {31'b0, g_ov(s)}, 32'd1);
        chk({name, "_ans"}, g_ans(s), ea);
        chk({name, "_err"}, g_err(s), {28'b0, ee});
        @(posedge clk);
        #1;
    endtask

    task automatic slow_chk(input bit s, input logic [7:0] m, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] ea,
                            input logic [3:0] ee, input string name);
        bit acc;
        int w, lat, nb, bad;
        w = s ? 8 : 32;
        lat = 0; nb = 0; bad = 0;
        issue(s, m, a, b, 1, acc);
        chk({name, "_acc"}, {31'b0, acc}, 32'd1);
        for (int k = 1; k <= 3 * w && lat == 0; k++) begin
            @(negedge clk);
            if (g_ov(s)) lat = k;
            else begin
                if (g_busy(s)) nb++;
                if (g_ir(s)) bad++;
            end
        end
        chk({name, "_lat"}, lat, w + 1);
        chk({name, "_busycyc"}, nb, w);
        chk({name, "_irdy_busy"}, bad, 0);
        chk({name, "_ans"}, g_ans(s), ea);
        chk({name, "_err"}, g_err(s), {28'b0, ee});
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit s);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk);
            #1;
            if ((s ? q8.size() : q32.size()) == 0 && !g_ov(s) && !g_busy(s)) done = 1'b1;
        end
        chk(s ? "drain8" : "drain32", {31'b0, done}, 32'd1);
    endtask

    function automatic logic [31:0] ropnd(input int w);
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r = 32'h0;
            1: r = 32'h1;
            2: r = 32'hFFFF_FFFF;
            3: r = 32'h1 << (w - 1);
            4: r = (32'h1 << (w - 1)) - 32'h1;
            default: ;
        endcase
        if (w == 8) r = r & 32'hFF;
        return r;
    endfunction

    function automatic logic [7:0] rmode();
        int k;
        k = $urandom_range(0, 19);
        if (k < 10) return 8'(k);
        if (k < 18) return 8'h40 + 8'(k - 10);
        return 8'($urandom);
    endfunction

    initial begin
        bit acc;
        bit all_acc;
        checks = 0; errors = 0;
        rst = 1'b1; rand_en = 1'b0; or_fix = 1'b1; or8 = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; m32 = '0;
        iv8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ans", ans32, 32'h0);
        chk("rst_err", {28'b0, err32}, 32'h0);
        chk("rst_ov", {31'b0, ov32}, 32'h0);
        chk("rst_busy", {31'b0, busy32}, 32'h0);
        chk("rst_irdy", {31'b0, ir32}, 32'h1);
        chk("rst_irdy8", {31'b0, ir8}, 32'h1);
        @(posedge clk);
        #1;

        // Fast stream, back to back
        obs_cyc.delete();
        obs_ans.delete();
        all_acc = 1'b1;
        issue(0, 8'h01, 32'd5, 32'd7, 1, acc); all_acc &= acc;
        issue(0, 8'h00, 32'd3, 32'd5, 1, acc); all_acc &= acc;
        issue(0, 8'h08, 32'hFFFF_FFFF, 32'd1, 1, acc); all_acc &= acc;
        chk("stream_irdy", {31'b0, all_acc}, 32'd1);
        drain(0);
        chk("stream_n", obs_ans.size(), 3);
        if (obs_ans.size() == 3) begin
            chk("stream_a0", obs_ans[0], 32'd12);
            chk("stream_a1", obs_ans[1], 32'hFFFF_FFFE);
            chk("stream_a2", obs_ans[2], 32'd1);
            chk("stream_gap1", obs_cyc[1] - obs_cyc[0], 1);
            chk("stream_gap2", obs_cyc[2] - obs_cyc[1], 1);
        end

        // Slow ops with latency and specials
        slow_chk(0, 8'h41, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4'b0000, "mulh");
        slow_chk(0, 8'h44, 32'd7, 32'd0, 32'hFFFF_FFFF, 4'b0010, "div_dz");
        slow_chk(0, 8'h46, 32'd7, 32'd0, 32'd7, 4'b0010, "rem_dz");
        slow_chk(0, 8'h44, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0100, "div_ovf");
        slow_chk(0, 8'h46, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 4'b0000, "rem_neg");

        // Backpressure
        or_fix = 1'b0;
        issue(0, 8'h01, 32'd1, 32'd1, 1, acc);
        chk("bp_acc", {31'b0, acc}, 32'd1);
        iv32 = 1'b1; m32 = 8'h01; a32 = 32'd9; b32 = 32'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_ans", ans32, 32'd2);
            chk("bp_ov", {31'b0, ov32}, 32'd1);
            chk("bp_irdy", {31'b0, ir32}, 32'd0);
            @(posedge clk);
            #1;
        end
        or_fix = 1'b1;
        issue(0, 8'h01, 32'd2, 32'd2, 1, acc);
        chk("bp_release_acc", {31'b0, acc}, 32'd1);
        @(negedge clk);
        chk("bp_next_ans", ans32, 32'd4);
        chk("bp_next_ov", {31'b0, ov32}, 32'd1);
        @(posedge clk);
        #1;
        drain(0);

        // Reset mid-operation, then illegal mode
        issue(0, 8'h45, 32'd100, 32'd7, 1, acc);
        chk("rstmid_acc", {31'b0, acc}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q32.delete();
        @(negedge clk);
        chk("rstmid_ans", ans32, 32'h0);
        chk("rstmid_err", {28'b0, err32}, 32'h0);
        chk("rstmid_ov", {31'b0, ov32}, 32'h0);
        chk("rstmid_busy", {31'b0, busy32}, 32'h0);
        chk("rstmid_irdy", {31'b0, ir32}, 32'h1);
        @(posedge clk);
        #1;
        fast_chk(0, 8'hFF, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 4'b0001, "illegal");
        drain(0);

        // WIDTH=8 instance
        slow_chk(1, 8'h43, 32'hFF, 32'hFF, 32'hFE, 4'b0000, "w8_mulhu");
        fast_chk(1, 8'h05, 32'h80, 32'h0B, 32'h10, 4'b0000, "w8_rmv");
        drain(1);

        // Randomised traffic with random backpressure, WIDTH=32
        rand_en = 1'b1;
        for (int i = 0; i < 120; i++) begin
            issue(0, rmode(), ropnd(32), ropnd(32), 200, acc);
            if (!acc) chk("rand32_accept", {31'b0, acc}, 32'd1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_en = 1'b0;
        drain(0);

        // Randomised traffic, WIDTH=8
        for (int i = 0; i < 80; i++) begin
            issue(1, rmode(), ropnd(8), ropnd(8), 50, acc);
            if (!acc) chk("rand8_accept", {31'b0, acc}, 32'd1);
        end
        drain(1);

        chk("q32_empty", q32.size(), 0);
        chk("q8_empty", q8.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
